// File: rtl/valu_wb_if.sv
// valu_wb_if: issue and register-file writeback channels of the vector ALU
// writeback unit. The issuer/register-file side uses the master modport; the
// writeback unit uses the slave modport.
interface valu_wb_if #(
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);

  // Issue channel (operation presented to the ALU)
  logic                 issue_valid;
  logic [4:0]           issue_op;
  logic [AW-1:0]        issue_vdst;
  logic [AW-1:0]        issue_rdst;
  logic                 issue_ready;

  // Register-file write ports
  logic                 wb_ready;
  logic                 vwb_valid;
  logic [AW-1:0]        vwb_addr;
  logic [3:0][31:0]     vwb_data;
  logic                 rwb_valid;
  logic [AW-1:0]        rwb_addr;
  logic [31:0]          rwb_data;

  modport master (
    output issue_valid, issue_op, issue_vdst, issue_rdst, wb_ready,
    input  issue_ready, vwb_valid, vwb_addr, vwb_data,
           rwb_valid, rwb_addr, rwb_data
  );

  modport slave (
    input  issue_valid, issue_op, issue_vdst, issue_rdst, wb_ready,
    output issue_ready, vwb_valid, vwb_addr, vwb_data,
           rwb_valid, rwb_addr, rwb_data
  );
endinterface

// File: rtl/valu_writeback.sv
// valu_writeback: follows every operation issued to the 4-lane vector ALU
// through its fixed-latency pipeline with a tag shift register, captures the
// vector or scalar result when the matching tag reaches the end, and offers it
// to the register file with a valid/ready handshake. A pending write that the
// register file refuses freezes the ALU (and the tag pipe) through alu_en_o.
//
// Optional feature: define VALU_SCOREBOARD_EN to track per-register busy bits
// and hold issue of any operation whose destination already has a write in
// flight (write-after-write protection).
module valu_writeback #(
  parameter int LAT  = 8,
  parameter int NREG = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  valu_wb_if.slave          bus,
  output logic              alu_en_o,
  input  logic [3:0][31:0]  vout_i,
  input  logic [31:0]       rout_i,
  output logic [NREG-1:0]   vbusy_o,
  output logic [NREG-1:0]   rbusy_o,
  output logic              idle_o
);

  localparam int AW = $clog2(NREG);

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_SCALAR = 2'd1,
    CLS_VECTOR = 2'd2
  } cls_e;

  typedef struct packed {
    logic          valid;
    cls_e          cls;
    logic [AW-1:0] dst;
  } tag_t;

  // Result class of an ALU opcode; 19-31 still use a pipeline slot but write nothing.
  function automatic cls_e op_class(input logic [4:0] op);
    cls_e c;
    case (op) inside
      5'd0, 5'd1, 5'd2, [5'd6:5'd9]: c = CLS_SCALAR;
      [5'd3:5'd5], [5'd10:5'd18]:    c = CLS_VECTOR;
      default:                       c = CLS_NONE;
    endcase
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  cls_e             issue_cls;
  logic [AW-1:0]    issue_dst;
  logic             issue_ready;
  logic             acc;
  logic             alu_en;
  logic             wb_pending;
  logic             wb_fire;

  tag_t             tag_q [LAT];
  tag_t             tag_d [LAT];
  tag_t             tail;
  logic             any_tag;

  logic             vwb_valid_q, vwb_valid_d;
  logic [AW-1:0]    vwb_addr_q,  vwb_addr_d;
  logic [3:0][31:0] vwb_data_q,  vwb_data_d;
  logic             rwb_valid_q, rwb_valid_d;
  logic [AW-1:0]    rwb_addr_q,  rwb_addr_d;
  logic [31:0]      rwb_data_q,  rwb_data_d;

  // ---------------------------------------------------------------------------
  // Issue decode and pipeline enable
  // ---------------------------------------------------------------------------
  // Classify the presented opcode and pick the destination of its file.
  always_comb begin
    issue_cls = op_class(bus.issue_op);
    issue_dst = (issue_cls == CLS_VECTOR) ? bus.issue_vdst : bus.issue_rdst;
  end

  // The ALU may advance whenever the result register is empty or drains now;
  // deliberately independent of issue_valid so the issuer cannot form a loop.
  assign wb_pending = vwb_valid_q || rwb_valid_q;
  assign wb_fire    = wb_pending && bus.wb_ready;
  assign alu_en     = !wb_pending || bus.wb_ready;
  assign acc        = bus.issue_valid && issue_ready;

  // ---------------------------------------------------------------------------
  // Tag pipeline: one entry per ALU stage, advancing only on enabled edges
  // ---------------------------------------------------------------------------
  // Next-state of the tag shift register.
  always_comb begin
    // NOTE: every variable gets a default at the top of a combinational block;
    // a path that leaves one unassigned would infer a latch.
    for (int i = 0; i < LAT; i++) begin
      tag_d[i] = tag_q[i];
    end
    if (alu_en) begin
      tag_d[0].valid = acc;
      tag_d[0].cls   = issue_cls;
      tag_d[0].dst   = issue_dst;
      for (int i = 1; i < LAT; i++) begin
        tag_d[i] = tag_q[i-1];
      end
    end
  end

  // Tag state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is reset (unlike a data RAM) because its valid bits
      // decide whether a result is captured; stale tags would write garbage.
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples its neighbour's pre-edge value, independent of statement order.
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign tail = tag_q[LAT-1];

  // ---------------------------------------------------------------------------
  // Result register and write handshake
  // ---------------------------------------------------------------------------
  // Drain on wb_ready, then capture the ALU output when a writing tag retires.
  // A load is only possible when the register is empty or draining this edge,
  // so the vector and scalar valids can never be high together.
  always_comb begin
    vwb_valid_d = vwb_valid_q;
    vwb_addr_d  = vwb_addr_q;
    vwb_data_d  = vwb_data_q;
    rwb_valid_d = rwb_valid_q;
    rwb_addr_d  = rwb_addr_q;
    rwb_data_d  = rwb_data_q;
    if (wb_fire) begin
      vwb_valid_d = 1'b0;
      rwb_valid_d = 1'b0;
    end
    if (alu_en && tail.valid) begin
      case (tail.cls)
        CLS_VECTOR: begin
          vwb_valid_d = 1'b1;
          vwb_addr_d  = tail.dst;
          vwb_data_d  = vout_i;
        end
        CLS_SCALAR: begin
          rwb_valid_d = 1'b1;
          rwb_addr_d  = tail.dst;
          rwb_data_d  = rout_i;
        end
        default: ;
      endcase
    end
  end

  // Result register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vwb_valid_q <= 1'b0;
      vwb_addr_q  <= '0;
      vwb_data_q  <= '0;
      rwb_valid_q <= 1'b0;
      rwb_addr_q  <= '0;
      rwb_data_q  <= '0;
    end else begin
      vwb_valid_q <= vwb_valid_d;
      vwb_addr_q  <= vwb_addr_d;
      vwb_data_q  <= vwb_data_d;
      rwb_valid_q <= rwb_valid_d;
      rwb_addr_q  <= rwb_addr_d;
      rwb_data_q  <= rwb_data_d;
    end
  end

  // Idle when no tag is travelling and nothing waits for the register file.
  always_comb begin
    any_tag = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      any_tag = any_tag | tag_q[i].valid;
    end
  end

  assign idle_o        = !any_tag && !wb_pending;
  assign alu_en_o      = alu_en;
  assign bus.vwb_valid = vwb_valid_q;
  assign bus.vwb_addr  = vwb_addr_q;
  assign bus.vwb_data  = vwb_data_q;
  assign bus.rwb_valid = rwb_valid_q;
  assign bus.rwb_addr  = rwb_addr_q;
  assign bus.rwb_data  = rwb_data_q;

  // ---------------------------------------------------------------------------
  // Write-after-write scoreboard
  // ---------------------------------------------------------------------------
`ifdef VALU_SCOREBOARD_EN
  logic [NREG-1:0] vbusy_q, vbusy_d;
  logic [NREG-1:0] rbusy_q, rbusy_d;
  logic            dst_busy;

  // Is the destination of the presented operation already owed a write?
  always_comb begin
    dst_busy = 1'b0;
    case (issue_cls)
      CLS_VECTOR: dst_busy = vbusy_q[bus.issue_vdst];
      CLS_SCALAR: dst_busy = rbusy_q[bus.issue_rdst];
      default:    dst_busy = 1'b0;
    endcase
  end

  // Clear on write completion first, then set on accept so a same-edge set wins.
  always_comb begin
    vbusy_d = vbusy_q;
    rbusy_d = rbusy_q;
    if (vwb_valid_q && bus.wb_ready) vbusy_d[vwb_addr_q] = 1'b0;
    if (rwb_valid_q && bus.wb_ready) rbusy_d[rwb_addr_q] = 1'b0;
    if (acc && issue_cls == CLS_VECTOR) vbusy_d[bus.issue_vdst] = 1'b1;
    if (acc && issue_cls == CLS_SCALAR) rbusy_d[bus.issue_rdst] = 1'b1;
  end

  // Busy-bit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vbusy_q <= '0;
      rbusy_q <= '0;
    end else begin
      vbusy_q <= vbusy_d;
      rbusy_q <= rbusy_d;
    end
  end

  assign issue_ready = alu_en && !dst_busy;
  assign vbusy_o     = vbusy_q;
  assign rbusy_o     = rbusy_q;
`else
  assign issue_ready = alu_en;
  assign vbusy_o     = '0;
  assign rbusy_o     = '0;
`endif

  assign bus.issue_ready = issue_ready;

endmodule

// File: tb/tb_valu_writeback.sv
// tb_valu_writeback: scenario tasks around valu_writeback with a cycle-level
// ALU pipeline stand-in and a queue-based reference model of in-flight
// operations (age in enabled cycles, class, destination, expected data).
module tb_valu_writeback;

  localparam int LAT  = 8;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  valu_wb_if #(.NREG(NREG)) bus ();

  logic             alu_en;
  logic [3:0][31:0] vout;
  logic [31:0]      rout;
  logic [NREG-1:0]  vbusy;
  logic [NREG-1:0]  rbusy;
  logic             idle;

  valu_writeback #(.LAT(LAT), .NREG(NREG)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .alu_en_o (alu_en),
    .vout_i   (vout),
    .rout_i   (rout),
    .vbusy_o  (vbusy),
    .rbusy_o  (rbusy),
    .idle_o   (idle)
  );

  // ALU stand-in: operand data enters on each enabled edge, leaves LAT later.
  logic [3:0][31:0] alu_vin;
  logic [31:0]      alu_rin;
  logic [3:0][31:0] apv [LAT];
  logic [31:0]      apr [LAT];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        apv[i] <= '0;
        apr[i] <= '0;
      end
    end else if (alu_en) begin
      apv[0] <= alu_vin;
      apr[0] <= alu_rin;
      for (int i = 1; i < LAT; i++) begin
        apv[i] <= apv[i-1];
        apr[i] <= apr[i-1];
      end
    end
  end
  assign vout = apv[LAT-1];
  assign rout = apr[LAT-1];

  // Reference model: every accepted operation, oldest first.
  typedef struct {
    int               cls;   // 0 none, 1 scalar, 2 vector
    int               dst;
    logic [3:0][31:0] vd;
    logic [31:0]      rd;
    int               age;   // enabled edges since (and including) acceptance
  } op_t;

  op_t mq[$];
  int  ret_v[$];
  int  ret_r[$];
  int  total = 0;
  int  bad = 0;

  function automatic int cls_of(input logic [4:0] op);
    int o;
    o = int'(op);
    if (o <= 2 || (o >= 6 && o <= 9)) return 1;
    if (o <= 18) return 2;
    return 0;
  endfunction

  function automatic bit in_flight(input int c, input int d);
    foreach (mq[i]) if (mq[i].cls == c && mq[i].dst == d) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input bit v, input int op, input int vd, input int rd, input bit wr);
    bus.issue_valid = v;
    bus.issue_op    = op[4:0];
    bus.issue_vdst  = vd[AW-1:0];
    bus.issue_rdst  = rd[AW-1:0];
    bus.wb_ready    = wr;
    for (int k = 0; k < 4; k++) alu_vin[k] = $urandom;
    alu_rin = $urandom;
  endtask

  // One clock cycle: compare DUT to the model mid-cycle, then advance the model
  // across the rising edge. Returns at rising edge + 1.
  task automatic step();
    int c, d;
    bit pend, en, rdy, ev, er;
    logic [NREG-1:0] vb_e, rb_e;
    op_t n;
    op_t keep[$];
    @(negedge clk);
    c    = cls_of(bus.issue_op);
    d    = (c == 2) ? int'(bus.issue_vdst) : int'(bus.issue_rdst);
    pend = mq.size() > 0 && mq[0].cls != 0 && mq[0].age > LAT;
    en   = !pend || bus.wb_ready;
    rdy  = en;
    vb_e = '0;
    rb_e = '0;
`ifdef VALU_SCOREBOARD_EN
    if (c != 0 && in_flight(c, d)) rdy = 1'b0;
    foreach (mq[i]) begin
      if (mq[i].cls == 2) vb_e[mq[i].dst] = 1'b1;
      else if (mq[i].cls == 1) rb_e[mq[i].dst] = 1'b1;
    end
`endif
    ev = pend && mq[0].cls == 2;
    er = pend && mq[0].cls == 1;

    total++; if (alu_en !== en) begin bad++; $display("FAIL alu_en: got %0b expected %0b @%0t", alu_en, en, $time); end
    total++; if (bus.issue_ready !== rdy) begin bad++; $display("FAIL issue_ready: got %0b expected %0b @%0t", bus.issue_ready, rdy, $time); end
    total++; if (bus.vwb_valid !== ev) begin bad++; $display("FAIL vwb_valid: got %0b expected %0b @%0t", bus.vwb_valid, ev, $time); end
    total++; if (bus.rwb_valid !== er) begin bad++; $display("FAIL rwb_valid: got %0b expected %0b @%0t", bus.rwb_valid, er, $time); end
    total++; if (idle !== (mq.size() == 0)) begin bad++; $display("FAIL idle: got %0b expected %0b @%0t", idle, mq.size() == 0, $time); end
    total++; if (vbusy !== vb_e) begin bad++; $display("FAIL vbusy: got %0h expected %0h @%0t", vbusy, vb_e, $time); end
    total++; if (rbusy !== rb_e) begin bad++; $display("FAIL rbusy: got %0h expected %0h @%0t", rbusy, rb_e, $time); end
    if (ev) begin
      total++; if (int'(bus.vwb_addr) != mq[0].dst || bus.vwb_data !== mq[0].vd) begin
        bad++; $display("FAIL vwb_payload: got %0d/%0h expected %0d/%0h @%0t", bus.vwb_addr, bus.vwb_data, mq[0].dst, mq[0].vd, $time);
      end
    end
    if (er) begin
      total++; if (int'(bus.rwb_addr) != mq[0].dst || bus.rwb_data !== mq[0].rd) begin
        bad++; $display("FAIL rwb_payload: got %0d/%0h expected %0d/%0h @%0t", bus.rwb_addr, bus.rwb_data, mq[0].dst, mq[0].rd, $time);
      end
    end

    if (bus.vwb_valid === 1'b1 && bus.wb_ready) ret_v.push_back(int'(bus.vwb_addr));
    if (bus.rwb_valid === 1'b1 && bus.wb_ready) ret_r.push_back(int'(bus.rwb_addr));

    if (pend && bus.wb_ready) void'(mq.pop_front());
    if (en) begin
      foreach (mq[i]) mq[i].age++;
      foreach (mq[i]) if (!(mq[i].cls == 0 && mq[i].age > LAT)) keep.push_back(mq[i]);
      mq = keep;
      if (bus.issue_valid && rdy) begin
        n.cls = c; n.dst = d; n.vd = alu_vin; n.rd = alu_rin; n.age = 1;
        mq.push_back(n);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      drive(1'b0, 0, 0, 0, 1'b1);
      step();
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 0, 0, 0, 1'b1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.vwb_valid !== 1'b0 || bus.rwb_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got v=%0b r=%0b expected 0", bus.vwb_valid, bus.rwb_valid); end
    total++; if (bus.vwb_addr !== '0 || bus.rwb_addr !== '0 || bus.vwb_data !== '0 || bus.rwb_data !== '0) begin bad++; $display("FAIL reset_payload: got nonzero address/data expected 0"); end
    total++; if (vbusy !== '0 || rbusy !== '0) begin bad++; $display("FAIL reset_busy: got %0h/%0h expected 0", vbusy, rbusy); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle: got %0b expected 1", idle); end
    total++; if (alu_en !== 1'b1 || bus.issue_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got en=%0b rdy=%0b expected 1", alu_en, bus.issue_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [3:0][31:0] want;
    bit exp_busy;
    want = {32'd4, 32'd3, 32'd2, 32'd1};
    drive(1'b1, 3, 5, 0, 1'b1);
    alu_vin = want;
    step();
    for (int cyc = 1; cyc <= 10; cyc++) begin
      drive(1'b0, 0, 0, 0, 1'b1);
      total++; if (bus.vwb_valid !== (cyc == 9)) begin bad++; $display("FAIL single_valid: cycle %0d got %0b expected %0b", cyc, bus.vwb_valid, cyc == 9); end
      if (cyc == 9) begin
        total++; if (bus.vwb_addr !== 5'd5 || bus.vwb_data !== want) begin bad++; $display("FAIL single_data: got %0d/%0h expected 5/%0h", bus.vwb_addr, bus.vwb_data, want); end
      end
`ifdef VALU_SCOREBOARD_EN
      exp_busy = (cyc <= 9);
`else
      exp_busy = 1'b0;
`endif
      total++; if (vbusy[5] !== exp_busy) begin bad++; $display("FAIL single_busy: cycle %0d got %0b expected %0b", cyc, vbusy[5], exp_busy); end
      step();
    end
  endtask

  task automatic test_back_pressure();
    bit first_seen;
    int low_left, en_low;
    ret_r.delete();
    first_seen = 1'b0;
    low_left = 0;
    en_low = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (!first_seen && bus.rwb_valid === 1'b1) begin
        first_seen = 1'b1;
        low_left = 3;
      end
      drive(cyc < 8, 0, 0, cyc, low_left == 0);
      if (low_left > 0) low_left--;
      #1;
      if (alu_en !== 1'b1) en_low++;
      step();
    end
    total++; if (en_low != 3) begin bad++; $display("FAIL bp_stall_cycles: got %0d expected 3", en_low); end
    total++; if (ret_r.size() != 8) begin bad++; $display("FAIL bp_count: got %0d expected 8", ret_r.size()); end
    for (int i = 0; i < ret_r.size() && i < 8; i++) begin
      total++; if (ret_r[i] != i) begin bad++; $display("FAIL bp_order: slot %0d got %0d expected %0d", i, ret_r[i], i); end
    end
  endtask

  task automatic test_no_wb();
    drive(1'b1, 20, 2, 2, 1'b1);
    step();
    for (int cyc = 1; cyc <= 12; cyc++) begin
      drive(1'b0, 0, 0, 0, 1'b1);
      total++; if (bus.vwb_valid !== 1'b0 || bus.rwb_valid !== 1'b0) begin bad++; $display("FAIL nowb_write: cycle %0d got v=%0b r=%0b expected 0", cyc, bus.vwb_valid, bus.rwb_valid); end
      total++; if (idle !== (cyc >= 9)) begin bad++; $display("FAIL nowb_idle: cycle %0d got %0b expected %0b", cyc, idle, cyc >= 9); end
      step();
    end
  endtask

  task automatic test_waw();
    int acc_cyc, want;
    drive(1'b1, 6, 0, 3, 1'b1);
    step();
    acc_cyc = -1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (acc_cyc < 0) drive(1'b1, 6, 0, 3, 1'b1);
      else drive(1'b0, 0, 0, 0, 1'b1);
      #1;
      if (acc_cyc < 0 && bus.issue_ready === 1'b1) acc_cyc = cyc;
      step();
    end
`ifdef VALU_SCOREBOARD_EN
    want = 10;
`else
    want = 1;
`endif
    total++; if (acc_cyc != want) begin bad++; $display("FAIL waw_accept_cycle: got %0d expected %0d", acc_cyc, want); end
  endtask

  task automatic test_mixed();
    int n_acc;
    bit vec_turn, took;
    ret_v.delete();
    ret_r.delete();
    n_acc = 0;
    vec_turn = 1'b1;
    for (int cyc = 0; cyc < 150 && n_acc < 8; cyc++) begin
      if (vec_turn) drive(1'b1, 4, 1, 0, $urandom_range(0, 3) != 0);
      else drive(1'b1, 7, 0, 1, $urandom_range(0, 3) != 0);
      #1;
      took = bus.issue_ready === 1'b1;
      step();
      if (took) begin
        n_acc++;
        vec_turn = !vec_turn;
      end
    end
    drain(40);
    total++; if (n_acc != 8) begin bad++; $display("FAIL mixed_issue_timeout: got %0d accepted expected 8", n_acc); end
    total++; if (ret_v.size() != 4 || ret_r.size() != 4) begin bad++; $display("FAIL mixed_counts: got v=%0d r=%0d expected 4/4", ret_v.size(), ret_r.size()); end
    foreach (ret_v[i]) begin
      total++; if (ret_v[i] != 1) begin bad++; $display("FAIL mixed_vaddr: got %0d expected 1", ret_v[i]); end
    end
    foreach (ret_r[i]) begin
      total++; if (ret_r[i] != 1) begin bad++; $display("FAIL mixed_raddr: got %0d expected 1", ret_r[i]); end
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 31), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 9) < 7);
      step();
    end
    drain(60);
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL random_drain_idle: got %0b expected 1", idle); end
  endtask

  task automatic test_reset_mid();
    int writes;
    for (int cyc = 0; cyc < 4; cyc++) begin
      drive(1'b1, 0, 0, cyc, 1'b1);
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    total++; if (bus.vwb_valid !== 1'b0 || bus.rwb_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got v=%0b r=%0b expected 0", bus.vwb_valid, bus.rwb_valid); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL midrst_idle: got %0b expected 1", idle); end
    total++; if (vbusy !== '0 || rbusy !== '0) begin bad++; $display("FAIL midrst_busy: got %0h/%0h expected 0", vbusy, rbusy); end
    total++; if (alu_en !== 1'b1 || bus.rwb_addr !== '0 || bus.rwb_data !== '0) begin bad++; $display("FAIL midrst_state: got en=%0b addr=%0d data=%0h expected 1/0/0", alu_en, bus.rwb_addr, bus.rwb_data); end
    drive(1'b0, 0, 0, 0, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    writes = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (bus.vwb_valid === 1'b1 || bus.rwb_valid === 1'b1) writes++;
      drive(1'b0, 0, 0, 0, 1'b1);
      step();
    end
    total++; if (writes != 0) begin bad++; $display("FAIL midrst_late_write: got %0d write cycles expected 0", writes); end
  endtask

  initial begin
    test_reset();
    test_single();
    drain(4);
    test_back_pressure();
    drain(4);
    test_no_wb();
    drain(2);
    test_waw();
    drain(12);
    test_mixed();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

endmodule

// File: doc/valu_writeback.md
# valu_writeback

Tracks every operation issued to the 4-lane vector ALU through that ALU's fixed-latency pipeline. Captures the ALU's vector or scalar result when the matching operation reaches the output, and presents it to the register-file write ports with a valid/ready handshake. It drives the ALU's `en` stall input so that back-pressure from the register file freezes the whole ALU pipeline. An optional scoreboard exports per-register busy bits and blocks write-after-write issue.

## Interface
- `LAT`, 8: enabled ALU cycles from operand presentation to valid `vout`/`rout`.
- `NREG`, 32: registers per file (vector and scalar). Address width is `$clog2(NREG)`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `issue_valid` in 1: an operation is presented to the ALU this cycle.
- `issue_op` in 5: ALU opcode, identical to the ALU's `op` input.
- `issue_vdst` in log2(NREG): vector destination.
- `issue_rdst` in log2(NREG): scalar destination.
- `issue_ready` out 1: the operation is accepted this cycle.
- `alu_en` out 1: connects to the ALU `en` input.
- `vout` in 4x32: ALU vector result.
- `rout` in 32: ALU scalar result.
- `wb_ready` in 1: the register-file write port accepts this cycle.
- `vwb_valid` out 1: a vector write is pending.
- `vwb_addr` out log2(NREG): vector write address.
- `vwb_data` out 4x32: vector write data.
- `rwb_valid` out 1: a scalar write is pending.
- `rwb_addr` out log2(NREG): scalar write address.
- `rwb_data` out 32: scalar write data.
- `vbusy` out NREG: vector registers with an in-flight write.
- `rbusy` out NREG: scalar registers with an in-flight write.
- `idle` out 1: no valid tag in flight and no pending write.

## Operation
- Opcode class:
  - Scalar result: 0, 1, 2, 6, 7, 8, 9.
  - Vector result: 3, 4, 5, 10–18.
  - 19–31 give no writeback. They still occupy a pipeline slot.
- Accept: `acc = issue_valid && issue_ready`.
- Tag pipeline: stages 1..LAT, each {valid, class, dst}.
  - On an enabled edge, stage 1 <= {acc, class(issue_op), dst}.
  - On an enabled edge, stage i <= stage i-1.
  - Stage contents hold whenever `alu_en`=0.
- Result register: a single entry.
  - On an enabled edge where stage LAT is valid with a writeback class, it loads the ALU result of that class. It sets `vwb_valid` or `rwb_valid` (never both) and loads the matching address and data.
  - When stage LAT is valid with class "none", nothing is loaded.
- Handshake:
  - A write completes on an edge where (`vwb_valid`||`rwb_valid`) && `wb_ready`.
  - The valid flag clears unless a new result loads on the same edge.
  - Address and data stay stable while valid is high and `wb_ready` is low.
- `alu_en = !(vwb_valid||rwb_valid) || wb_ready`. This is combinational, with no dependence on `issue_valid`.
- `idle` = no valid tag in stages 1..LAT && both wb valids low.

## Timing
- Reset values:
  - All tag stages invalid.
  - `vwb_valid`=`rwb_valid`=0; addresses and data are 0.
  - `vbusy`=`rbusy`=0.
  - `idle`=1.
  - After reset, `alu_en`=1 and `issue_ready`=1.
- Latency: an operation accepted at edge E is in the result register after LAT+1 enabled edges. With no stall, `*wb_valid` goes high in cycle E+LAT+1.
- Throughput: one operation per cycle while `wb_ready`=1.
- Stall:
  - With a pending write and `wb_ready`=0, `alu_en`=0 and `issue_ready`=0.
  - There are zero lost or duplicated results.
- Reset mid-operation: all in-flight tags and the pending write are discarded immediately. The ALU is reset by the same `rst_n`.

## Configuration
- `VALU_SCOREBOARD_EN` defined:
  - A busy bit is set on the edge an operation is accepted, for its destination in its class's file.
  - The busy bit clears on the edge its write completes.
  - If set and clear hit the same bit on one edge, set wins.
  - `issue_ready = alu_en && !busy[dst]` for the issued class. Class "none" checks nothing.
- `VALU_SCOREBOARD_EN` undefined:
  - `vbusy`=`rbusy`=0 constant.
  - `issue_ready = alu_en`.

## Test plan
- Single operation: issue `op`=3 with `vdst`=5 at cycle 0, and the ALU returns `vout`={1,2,3,4} at stage LAT. Required: `vwb_valid`=1, `vwb_addr`=5, data {1,2,3,4} at cycle 9; with the scoreboard, `vbusy[5]` is 1 during cycles 1–9 and 0 at cycle 10.
- Back-pressure: eight back-to-back scalar operations (`op`=0, `rdst` 0–7) with `wb_ready` held low for 3 cycles after the first result. Required: `alu_en`=0 for exactly 3 cycles, results retire in order 0–7, none lost or duplicated.
- No-writeback opcode: issue `op`=20. Required: no write ever asserts and `idle` returns to 1 after 8 cycles.
- WAW with the scoreboard: issue `op`=6 with `rdst`=3, then `rdst`=3 again the next cycle. Required: the second is held (`issue_ready`=0) until cycle 10, the edge where the first write completes.
- Mixed classes: alternate `op`=4 with `vdst`=1 and `op`=7 with `rdst`=1. Required: `vwb_valid` and `rwb_valid` never high together, and every result goes to the correct file.
- Reset: assert `rst_n` low at cycle 4 with 4 operations in flight. Required: all outputs at reset values immediately, and no write occurs after release.
